// File: rtl/mfp_ahb_lite_master_pkg.sv
// AHB-Lite encodings, the command record and the address-alignment helper
// shared by the mfp AHB-Lite master.
package mfp_ahb_lite_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } ahb_cmd_t;

    // HADDR must be naturally aligned to the transfer size.
    function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] aligned;
        aligned = addr;
        case (size)
            HSIZE_BYTE: aligned = addr;
            HSIZE_HALF: aligned[0] = 1'b0;
            default:    aligned[1:0] = 2'b00;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite initiator: valid/ready commands become SINGLE transfers with the next
// address phase overlapping the current data phase; handles waits and 2-cycle ERROR.
module mfp_ahb_lite_master
    import mfp_ahb_lite_master_pkg::*;
#(
    parameter logic [3:0] HPROT_VALUE = 4'b0011,
    parameter bit         PIPELINED   = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_error,
    output logic [31:0] rsp_rdata,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    ahb_cmd_t    a_cmd;
    ahb_cmd_t    cmd_in;
    logic        a_valid;
    logic        a_hold;
    logic        d_valid;
    logic        d_write;
    logic [31:0] d_wdata;

    logic [2:0]  cmd_size_legal;
    logic        err_first;
    logic        a_advance;
    logic        d_retire;
    logic        ready_base;
    logic        cmd_accept;

    assign cmd_size_legal = cmd_size & 3'b011;
    assign cmd_in = '{addr:  align_addr(cmd_addr, cmd_size_legal),
                      write: cmd_write,
                      size:  cmd_size_legal,
                      wdata: cmd_wdata};

    // First cycle of an ERROR response: the pending address phase must be withdrawn.
    assign err_first  = d_valid && HRESP && !HREADY;
    assign a_advance  = a_valid && !a_hold && HREADY;
    assign d_retire   = d_valid && HREADY;
    assign ready_base = !a_valid || (HREADY && !a_hold && !err_first);
    assign cmd_ready  = PIPELINED ? ready_base : (ready_base && (!d_valid || d_retire));
    assign cmd_accept = cmd_valid && cmd_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            a_valid <= 1'b0;
            a_hold  <= 1'b0;
            a_cmd   <= '{addr: 32'h0, write: 1'b0, size: HSIZE_WORD, wdata: 32'h0};
        end else begin
            if (cmd_accept) begin
                a_valid <= 1'b1;
                a_cmd   <= cmd_in;
            end else if (a_advance) begin
                a_valid <= 1'b0;
            end
            // The held command replays as NONSEQ once the ERROR's second cycle is taken.
            if (err_first && a_valid) begin
                a_hold <= 1'b1;
            end else if (HREADY) begin
                a_hold <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_wdata <= 32'h0;
        end else if (a_advance) begin
            d_valid <= 1'b1;
            d_write <= a_cmd.write;
            d_wdata <= a_cmd.wdata;
        end else if (d_retire) begin
            d_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= d_retire;
            rsp_error <= d_retire && HRESP;
            rsp_rdata <= (d_retire && !d_write) ? HRDATA : 32'h0;
        end
    end

    assign HADDR     = a_cmd.addr;
    assign HWRITE    = a_cmd.write;
    assign HSIZE     = a_cmd.size;
    assign HTRANS    = (a_valid && !a_hold) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HWDATA    = d_wdata;
    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VALUE;

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed and randomized bench for mfp_ahb_lite_master with an in-bench AHB slave
// and an in-order transaction model of the expected bus traffic and responses.
module tb_mfp_ahb_lite_master;
    import mfp_ahb_lite_master_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    mfp_ahb_lite_master dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } exp_issue_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_rsp_t;

    int vectors = 0;
    int miscompares = 0;

    exp_issue_t  issue_q[$];
    exp_rsp_t    rsp_q[$];
    logic [31:0] ref_mem[int unsigned];
    logic [31:0] slv_mem[int unsigned];

    // slave state
    bit          dp_active = 0;
    exp_issue_t  dp;
    int          dp_waits = 0;
    bit          dp_err = 0;
    bit          dp_err_second = 0;
    int          pending_waits = -1;
    bit          random_waits = 0;

    localparam int MAXC = 8192;
    logic [1:0]  o_htrans[MAXC];
    logic [31:0] o_haddr[MAXC];
    logic [31:0] o_hwdata[MAXC];
    logic        o_rsp[MAXC];
    logic        o_ready[MAXC];
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          last_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit is_err_addr(input logic [31:0] a);
        return a[31:24] == 8'h1F;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [2:0] sz);
        int unsigned gran;
        gran = 1 << sz;
        return a - (a % gran);
    endfunction

    function automatic logic [31:0] mem_rd(input int unsigned w);
        return slv_mem.exists(w) ? slv_mem[w] : 32'h0;
    endfunction

    task automatic model_accept();
        exp_issue_t  it;
        exp_rsp_t    r;
        int unsigned w;
        it.size  = cmd_size % 3'd4;
        it.addr  = exp_addr(cmd_addr, it.size);
        it.write = cmd_write;
        it.wdata = cmd_wdata;
        issue_q.push_back(it);
        w = it.addr / 4;
        r.err = is_err_addr(it.addr);
        if (it.write) begin
            r.rdata = 32'h0;
            if (!r.err) ref_mem[w] = it.wdata;
        end else begin
            r.rdata = r.err ? 32'h0 : (ref_mem.exists(w) ? ref_mem[w] : 32'h0);
        end
        rsp_q.push_back(r);
    endtask

    task automatic drive_slave();
        if (!dp_active) begin
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        end else if (dp_err) begin
            HREADY = dp_err_second; HRESP = 1'b1; HRDATA = 32'h0;
        end else if (dp_waits > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
            HRDATA = dp.write ? $urandom : mem_rd(dp.addr / 4);
        end
    endtask

    task automatic tick();
        exp_rsp_t   r;
        exp_issue_t it;
        bit         taken, done;
        @(negedge HCLK);
        if (rsp_valid === 1'b1 && rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            check("rsp_error", rsp_error, r.err);
            check("rsp_rdata", rsp_rdata, r.rdata);
        end else if (rsp_q.size() == 0) begin
            check("rsp_valid_idle", rsp_valid, 0);
        end
        drive_slave();
        #1;
        if (cyc < MAXC) begin
            o_htrans[cyc] = HTRANS; o_haddr[cyc] = HADDR; o_hwdata[cyc] = HWDATA;
            o_rsp[cyc] = rsp_valid; o_ready[cyc] = cmd_ready;
        end
        last_acc = cmd_valid && cmd_ready;
        if (last_acc) begin
            acc_cyc = cyc;
            model_accept();
        end
        taken = (HTRANS == HTRANS_NONSEQ) && HREADY;
        done  = dp_active && HREADY;
        if (done) begin
            if (dp.write) check("hwdata", HWDATA, dp.wdata);
            if (dp.write && !dp_err) slv_mem[dp.addr / 4] = HWDATA;
            dp_active = 0;
        end else if (dp_active) begin
            if (dp_err) dp_err_second = 1;
            else dp_waits--;
        end
        if (taken) begin
            if (issue_q.size() == 0) begin
                check("spurious_nonseq", HTRANS, HTRANS_IDLE);
            end else begin
                it = issue_q.pop_front();
                check("haddr", HADDR, it.addr);
                check("hwrite", HWRITE, it.write);
                check("hsize", HSIZE, it.size);
                dp = it;
                dp_active = 1;
                dp_err = is_err_addr(it.addr);
                dp_err_second = 0;
                if (dp_err) dp_waits = 0;
                else if (pending_waits >= 0) dp_waits = pending_waits;
                else dp_waits = random_waits ? int'($urandom_range(0, 2)) : 0;
                pending_waits = -1;
            end
        end
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = d;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 100);
        check("cmd_accept", last_acc, 1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain();
        int n;
        n = 0;
        cmd_valid = 1'b0;
        while (rsp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        tick();
        check("drain_rsp_q", rsp_q.size(), 0);
        check("drain_issue_q", issue_q.size(), 0);
    endtask

    initial begin
        int          n0, c;
        int          acc[4];
        logic        w;
        logic [31:0] a;
        logic [2:0]  sz;

        HRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0; cmd_wdata = 32'h0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        #12;
        check("rst_htrans", HTRANS, HTRANS_IDLE);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwrite", HWRITE, 0);
        check("rst_hsize", HSIZE, 3'b010);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_error", rsp_error, 0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_hburst", HBURST, 3'b000);
        check("rst_hmastlock", HMASTLOCK, 0);
        check("rst_hprot", HPROT, 4'b0011);
        check("rst_cmd_ready", cmd_ready, 1);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        idle(2);

        // write then read back, zero-wait slave
        send(1'b1, 32'h8000_0010, HSIZE_WORD, 32'hDEAD_BEEF);
        n0 = acc_cyc;
        send(1'b0, 32'h8000_0010, HSIZE_WORD, 32'h0);
        idle(5);
        check("t1_nonseq_c1", o_htrans[n0+1], HTRANS_NONSEQ);
        check("t1_nonseq_c2", o_htrans[n0+2], HTRANS_NONSEQ);
        check("t1_haddr_c2", o_haddr[n0+2], 32'h8000_0010);
        check("t1_hwdata_c2", o_hwdata[n0+2], 32'hDEAD_BEEF);
        check("t1_rsp_c3", o_rsp[n0+3], 1);
        check("t1_rsp_c4", o_rsp[n0+4], 1);

        // two wait states with a second command parked in the address phase
        pending_waits = 2;
        send(1'b0, 32'hBFC0_0000, HSIZE_WORD, 32'h1234_5678);
        n0 = acc_cyc;
        send(1'b1, 32'h8000_0020, HSIZE_WORD, 32'h0BAD_F00D);
        idle(8);
        for (int k = 2; k <= 4; k++) begin
            check("t2_htrans_hold", o_htrans[n0+k], HTRANS_NONSEQ);
            check("t2_haddr_hold", o_haddr[n0+k], 32'h8000_0020);
            check("t2_hwdata_hold", o_hwdata[n0+k], 32'h1234_5678);
        end
        check("t2_ready_wait", o_ready[n0+2], 0);
        check("t2_rsp_c3", o_rsp[n0+3], 0);
        check("t2_rsp_c4", o_rsp[n0+4], 0);
        check("t2_rsp_c5", o_rsp[n0+5], 1);

        // four back-to-back writes
        for (int i = 0; i < 4; i++) begin
            send(1'b1, 32'h8000_0000 + 32'(4 * i), HSIZE_WORD, 32'hA500_0000 + 32'(i));
            acc[i] = acc_cyc;
        end
        idle(6);
        for (int i = 0; i < 4; i++) begin
            check("t3_accept_cycle", acc[i], acc[0] + i);
            check("t3_nonseq", o_htrans[acc[0]+1+i], HTRANS_NONSEQ);
            check("t3_haddr", o_haddr[acc[0]+1+i], 32'h8000_0000 + 32'(4 * i));
            check("t3_rsp", o_rsp[acc[0]+3+i], 1);
        end

        // ERROR on a read with a write pending in the address phase
        send(1'b0, 32'h1F00_0000, HSIZE_WORD, 32'h0);
        n0 = acc_cyc;
        send(1'b1, 32'h8000_0004, HSIZE_WORD, 32'hCAFE_0004);
        idle(8);
        check("t4_ready_err1", o_ready[n0+2], 0);
        check("t4_ready_err2", o_ready[n0+3], 0);
        check("t4_idle_err2", o_htrans[n0+3], HTRANS_IDLE);
        check("t4_haddr_err2", o_haddr[n0+3], 32'h8000_0004);
        check("t4_reissue", o_htrans[n0+4], HTRANS_NONSEQ);
        check("t4_reissue_addr", o_haddr[n0+4], 32'h8000_0004);
        check("t4_rsp_read", o_rsp[n0+4], 1);
        check("t4_rsp_gap", o_rsp[n0+5], 0);
        check("t4_rsp_write", o_rsp[n0+6], 1);

        // address alignment for byte and halfword
        send(1'b1, 32'h8000_0003, HSIZE_BYTE, 32'h0000_00EE);
        n0 = acc_cyc;
        send(1'b1, 32'h8000_0003, HSIZE_HALF, 32'hBEEF_0000);
        idle(5);
        check("t5_haddr_byte", o_haddr[n0+1], 32'h8000_0003);
        check("t5_haddr_half", o_haddr[n0+2], 32'h8000_0002);

        // reset in the middle of a wait state
        pending_waits = 5;
        send(1'b0, 32'hBFC0_0004, HSIZE_WORD, 32'h0);
        send(1'b1, 32'h8000_0008, HSIZE_WORD, 32'h0000_0001);
        idle(1);
        #2;
        HRESET = 1'b1;
        #1;
        check("t6_htrans_async", HTRANS, HTRANS_IDLE);
        check("t6_haddr_async", HADDR, 32'h0);
        check("t6_rsp_async", rsp_valid, 0);
        issue_q.delete();
        rsp_q.delete();
        ref_mem = slv_mem;
        dp_active = 0;
        pending_waits = -1;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        c = cyc;
        idle(4);
        check("t6_ready_after", o_ready[c], 1);
        check("t6_no_rsp", o_rsp[c], 0);

        // randomized traffic with waits and error-region hits
        random_waits = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            w = 1'($urandom_range(0, 1));
            a = (($urandom_range(0, 6) == 0) ? 32'h1F00_0000 : 32'h2000_0000)
                + 32'($urandom_range(0, 255));
            if (w) begin
                sz = ($urandom_range(0, 1) == 1) ? 3'd2 : 3'd6;
            end else begin
                sz = 3'($urandom_range(0, 5));
                if (sz >= 3'd3) sz = sz + 3'd1;
            end
            send(w, a, sz, $urandom);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
